// File: rtl/uart_sync_fifo_if.sv
// Handshake bundle between the APB UART register block and a uart_sync_fifo.
// The FIFO binds to the slave modport; the producer/consumer side binds to master.
interface uart_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 50
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    logic                  flush_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [CNT_WIDTH-1:0]  level_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, level_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART TX/RX paths: arbitrary depth via modulo pointers,
// occupancy level, almost-full/empty thresholds, sticky error flags and flush.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 50,
    parameter int AF_THRESH  = 48,
    parameter int AE_THRESH  = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    uart_sync_fifo_if.slave fifo
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C     = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C     = CNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [CNT_WIDTH-1:0]  level_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    // Pointers wrap at FIFO_DEPTH-1 so non-power-of-two depths use every entry.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign full   = (level_q == DEPTH_C);
    assign empty  = (level_q == '0);
    assign wr_acc = fifo.wr_en_i & ~full;
    assign rd_acc = fifo.rd_en_i & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (fifo.flush_i) begin
            // rd_data_q is deliberately kept so the last delivered word stays visible.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_q  <= next_ptr(rd_ptr_q);
                rd_data_q <= mem[rd_ptr_q];
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + CNT_WIDTH'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - CNT_WIDTH'(1);
            end
            if (fifo.wr_en_i && full) begin
                overflow_q <= 1'b1;
            end
            if (fifo.rd_en_i && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !fifo.flush_i) begin
            mem[wr_ptr_q] <= fifo.wr_data_i;
        end
    end

    assign fifo.rd_data_o      = rd_data_q;
    assign fifo.rd_valid_o     = rd_valid_q;
    assign fifo.full_o         = full;
    assign fifo.empty_o        = empty;
    assign fifo.almost_full_o  = (level_q >= AF_C);
    assign fifo.almost_empty_o = (level_q <= AE_C);
    assign fifo.level_o        = level_q;
    assign fifo.overflow_o     = overflow_q;
    assign fifo.underflow_o    = underflow_q;
endmodule
